// File: rtl/scmp_opfetch_pkg.sv
// Shared fetch/execute definitions for the SC/MP core: fetch FSM states and
// page-wrapping address helpers used by both instruction fetch and EA computation.
package scmp_opfetch_pkg;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_OP_RD,
        FS_DISP_RD,
        FS_DONE
    } FETCH_STATE_t;

    // Opcodes with bit 7 set carry a displacement/immediate byte.
    function automatic logic is_two_byte(input logic [7:0] op);
        return op[7];
    endfunction

    // SC/MP increments only the 12-bit in-page offset; the page never changes.
    function automatic logic [15:0] pc_inc12(input logic [15:0] addr);
        logic [11:0] low;
        low = addr[11:0] + 12'd1;
        return {addr[15:12], low};
    endfunction

endpackage

// File: rtl/scmp_opfetch_if.sv
// Fetch-side bundle: memory read bus towards the system and the op/disp
// handshake towards the microcode sequencer.
interface scmp_opfetch_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  op;
    logic [7:0]  disp;
    logic        op_valid;
    logic        op_ack;

    modport master (
        output mem_addr, mem_rd, op, disp, op_valid,
        input  mem_ack, mem_rdata, op_ack
    );

    modport slave (
        input  mem_addr, mem_rd, op, disp, op_valid,
        output mem_ack, mem_rdata, op_ack
    );
endinterface

// File: rtl/scmp_pc_inc12.sv
// Combinational 12-bit page-wrapping address incrementer.
module scmp_pc_inc12
    import scmp_opfetch_pkg::*;
(
    input  logic [15:0] addr,
    output logic [15:0] addr_inc
);
    assign addr_inc = pc_inc12(addr);
endmodule

// File: rtl/scmp_opfetch.sv
// SC/MP instruction fetch sequencer: pre-increments the PC within its page,
// reads opcode (and displacement for two-byte ops) and offers {op, disp}.
module scmp_opfetch
    import scmp_opfetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_go,
    input  logic          pc_ld,
    input  logic [15:0]   pc_wdata,
    output logic [15:0]   pc,
    output logic          busy,
    scmp_opfetch_if.master bus
);

    FETCH_STATE_t state_reg, state_next;
    logic [15:0]  pc_reg, pc_next;
    logic [15:0]  addr_reg, addr_next;
    logic         rd_reg, rd_next;
    logic [7:0]   op_reg, op_next;
    logic [7:0]   disp_reg, disp_next;

    logic [15:0]  inc_base;
    logic [15:0]  inc_pc;

    // One incrementer: a same-cycle pc_ld in IDLE replaces the PC as the base.
    assign inc_base = (state_reg == FS_IDLE && pc_ld) ? pc_wdata : pc_reg;

    scmp_pc_inc12 u_pc_inc12 (
        .addr     (inc_base),
        .addr_inc (inc_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FS_IDLE;
            pc_reg    <= RESET_PC;
            addr_reg  <= 16'h0000;
            rd_reg    <= 1'b0;
            op_reg    <= 8'h00;
            disp_reg  <= 8'h00;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            addr_reg  <= addr_next;
            rd_reg    <= rd_next;
            op_reg    <= op_next;
            disp_reg  <= disp_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        addr_next  = addr_reg;
        rd_next    = rd_reg;
        op_next    = op_reg;
        disp_next  = disp_reg;

        unique case (state_reg)
            FS_IDLE: begin
                if (fetch_go) begin
                    pc_next    = inc_pc;
                    addr_next  = inc_pc;
                    rd_next    = 1'b1;
                    state_next = FS_OP_RD;
                end else if (pc_ld) begin
                    pc_next = pc_wdata;
                end
            end
            FS_OP_RD: begin
                if (bus.mem_ack) begin
                    op_next = bus.mem_rdata;
                    if (is_two_byte(bus.mem_rdata)) begin
                        // Bus read stays asserted; only the address moves on.
                        pc_next    = inc_pc;
                        addr_next  = inc_pc;
                        state_next = FS_DISP_RD;
                    end else begin
                        disp_next  = 8'h00;
                        rd_next    = 1'b0;
                        state_next = FS_DONE;
                    end
                end
            end
            FS_DISP_RD: begin
                if (bus.mem_ack) begin
                    disp_next  = bus.mem_rdata;
                    rd_next    = 1'b0;
                    state_next = FS_DONE;
                end
            end
            FS_DONE: begin
                if (bus.op_ack) begin
                    state_next = FS_IDLE;
                end
            end
            default: state_next = FS_IDLE;
        endcase
    end

    assign pc           = pc_reg;
    assign busy         = (state_reg != FS_IDLE);
    assign bus.mem_addr = addr_reg;
    assign bus.mem_rd   = rd_reg;
    assign bus.op       = op_reg;
    assign bus.disp     = disp_reg;
    assign bus.op_valid = (state_reg == FS_DONE);

endmodule

// File: tb/tb_scmp_opfetch.sv
// Directed bench for scmp_opfetch: transaction-level fetch model, memory
// responder and a per-cycle compare process.
module tb_scmp_opfetch;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_go;
    logic        pc_ld;
    logic [15:0] pc_wdata;
    logic [15:0] pc;
    logic        busy;

    scmp_opfetch_if bus ();

    scmp_opfetch #(.RESET_PC(RESET_PC)) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch_go (fetch_go),
        .pc_ld    (pc_ld),
        .pc_wdata (pc_wdata),
        .pc       (pc),
        .busy     (busy),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem_arr [logic [15:0]];
    logic [15:0] model_pc;
    logic [7:0]  exp_op;
    logic [7:0]  exp_disp;
    bit          exp_busy = 1'b0;
    logic [15:0] exp_addrs [$];
    logic [15:0] rd_log [$];
    int          first_delay = 1;
    int          next_delay = 0;
    bit          stray_ack = 1'b0;
    int          ack_total = 0;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return 8'h00;
    endfunction

    function automatic logic [15:0] inc12(input logic [15:0] x);
        logic [11:0] lo;
        lo = x[11:0] + 12'd1;
        return {x[15:12], lo};
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare process and memory responder, evaluated just after each falling edge.
    initial begin
        int          cnt;
        bit          after;
        bit          prev_rd;
        bit          prev_ack;
        logic [15:0] prev_addr;
        cnt = 0; after = 1'b0; prev_rd = 1'b0; prev_ack = 1'b0; prev_addr = 16'h0000;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                cnt = 0; after = 1'b0; prev_rd = 1'b0; prev_ack = 1'b0;
                bus.mem_ack = 1'b0;
            end else begin
                check1("busy", busy, exp_busy);
                if (!exp_busy) begin
                    check1("op_valid_idle", bus.op_valid, 1'b0);
                    check1("mem_rd_idle", bus.mem_rd, 1'b0);
                    check16("pc_idle", pc, model_pc);
                end
                if (bus.op_valid) begin
                    check8("op", bus.op, exp_op);
                    check8("disp", bus.disp, exp_disp);
                    check16("pc_done", pc, model_pc);
                end
                if (prev_rd && !prev_ack) begin
                    check1("mem_rd_held", bus.mem_rd, 1'b1);
                    check16("mem_addr_held", bus.mem_addr, prev_addr);
                end
                prev_rd   = bus.mem_rd;
                prev_addr = bus.mem_addr;
                if (!bus.mem_rd) begin
                    cnt = 0;
                    after = 1'b0;
                    bus.mem_ack   = stray_ack;
                    bus.mem_rdata = 8'hFF;
                end else if (cnt >= (after ? next_delay : first_delay)) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_byte(bus.mem_addr);
                    rd_log.push_back(bus.mem_addr);
                    ack_total++;
                    if (exp_addrs.size() > 0) begin
                        check16("read_addr", bus.mem_addr, exp_addrs.pop_front());
                    end else begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_read: got addr %h expected no read", bus.mem_addr);
                    end
                    cnt = 0;
                    after = 1'b1;
                end else begin
                    bus.mem_ack = 1'b0;
                    cnt++;
                end
                prev_ack = bus.mem_ack && bus.mem_rd;
            end
        end
    end

    task automatic load_pc(input logic [15:0] v);
        pc_ld = 1'b1;
        pc_wdata = v;
        @(negedge clk);
        pc_ld = 1'b0;
        model_pc = v;
        $display("pc_ld %h", v);
    endtask

    // One full instruction fetch; lop/ldisp/lpc/llat are hand-computed literals.
    task automatic do_fetch(input bit ld, input logic [15:0] wdata, input int fd,
                            input int ackw, input bit pulses,
                            input logic [7:0] lop, input logic [7:0] ldisp,
                            input logic [15:0] lpc, input int llat);
        logic [15:0] base, a1, a2, fin;
        logic [7:0]  o, d;
        int          lat;
        base = ld ? wdata : model_pc;
        a1 = inc12(base);
        o = mem_byte(a1);
        if (o[7]) begin
            a2 = inc12(a1);
            d = mem_byte(a2);
            fin = a2;
        end else begin
            a2 = 16'h0000;
            d = 8'h00;
            fin = a1;
        end
        rd_log.delete();
        first_delay = fd;
        fetch_go = 1'b1;
        pc_ld = ld;
        pc_wdata = wdata;
        @(negedge clk);
        fetch_go = 1'b0;
        pc_ld = 1'b0;
        exp_busy = 1'b1;
        exp_addrs.push_back(a1);
        if (o[7]) exp_addrs.push_back(a2);
        exp_op = o;
        exp_disp = d;
        model_pc = fin;
        lat = 1;
        while (!bus.op_valid && lat < 100) begin
            if (pulses) begin
                case (lat)
                    1: fetch_go = 1'b1;
                    2: begin fetch_go = 1'b0; pc_ld = 1'b1; pc_wdata = 16'h7777; end
                    3: pc_ld = 1'b0;
                    default: ;
                endcase
            end
            @(negedge clk);
            lat++;
        end
        fetch_go = 1'b0;
        pc_ld = 1'b0;
        if (!bus.op_valid) begin
            errors++;
            checks++;
            $display("FAIL op_valid_timeout: got no op_valid after %0d cycles expected op_valid", lat);
            exp_busy = 1'b0;
            return;
        end
        if (llat > 0) check_int("latency", lat, llat);
        check8("lit_op", bus.op, lop);
        check8("lit_disp", bus.disp, ldisp);
        check16("lit_pc", pc, lpc);
        for (int k = 0; k < ackw; k++) begin
            @(negedge clk);
            check1("op_valid_held", bus.op_valid, 1'b1);
        end
        bus.op_ack = 1'b1;
        @(negedge clk);
        bus.op_ack = 1'b0;
        exp_busy = 1'b0;
        $display("fetch base=%h op=%h disp=%h pc=%h latency=%0d", base, bus.op, bus.disp, pc, lat);
    endtask

    initial begin
        int acks_before;
        rst = 1'b1;
        fetch_go = 1'b0;
        pc_ld = 1'b0;
        pc_wdata = 16'h0000;
        bus.op_ack = 1'b0;
        model_pc = RESET_PC;
        exp_op = 8'h00;
        exp_disp = 8'h00;
        mem_arr[16'h0001] = 8'h01;
        mem_arr[16'h1234] = 8'hC4;
        mem_arr[16'h1235] = 8'h5A;
        mem_arr[16'h2000] = 8'h90;
        mem_arr[16'h2001] = 8'h33;
        mem_arr[16'h4101] = 8'h01;
        mem_arr[16'h4102] = 8'h08;
        mem_arr[16'h4103] = 8'hC0;
        mem_arr[16'h4104] = 8'h12;

        repeat (3) @(negedge clk);
        check16("rst_pc", pc, 16'h0000);
        check16("rst_mem_addr", bus.mem_addr, 16'h0000);
        check1("rst_mem_rd", bus.mem_rd, 1'b0);
        check8("rst_op", bus.op, 8'h00);
        check8("rst_disp", bus.disp, 8'h00);
        check1("rst_op_valid", bus.op_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        $display("reset released");
        rst = 1'b0;
        @(negedge clk);

        // One-byte XAE from reset.
        do_fetch(1'b0, 16'h0000, 1, 0, 1'b0, 8'h01, 8'h00, 16'h0001, 3);
        check_int("t1_reads", rd_log.size(), 1);
        if (rd_log.size() > 0) check16("t1_addr", rd_log[0], 16'h0001);

        // Two-byte LDI, op_ack held off two cycles.
        load_pc(16'h1233);
        do_fetch(1'b0, 16'h0000, 1, 2, 1'b0, 8'hC4, 8'h5A, 16'h1235, 4);
        check_int("t2_reads", rd_log.size(), 2);
        if (rd_log.size() > 1) begin
            check16("t2_addr0", rd_log[0], 16'h1234);
            check16("t2_addr1", rd_log[1], 16'h1235);
        end

        // Page wrap: no carry into bit 12.
        load_pc(16'h2FFF);
        do_fetch(1'b0, 16'h0000, 1, 0, 1'b0, 8'h90, 8'h33, 16'h2001, 4);
        check_int("t3_reads", rd_log.size(), 2);
        if (rd_log.size() > 1) begin
            check16("t3_addr0", rd_log[0], 16'h2000);
            check16("t3_addr1", rd_log[1], 16'h2001);
        end

        // pc_ld together with fetch_go; disp cleared after a two-byte op.
        do_fetch(1'b1, 16'h4100, 1, 0, 1'b0, 8'h01, 8'h00, 16'h4101, 3);
        check_int("t4_reads", rd_log.size(), 1);
        if (rd_log.size() > 0) check16("t4_addr", rd_log[0], 16'h4101);

        // Slow memory; fetch_go and pc_ld pulsed while busy must be ignored.
        acks_before = ack_total;
        do_fetch(1'b0, 16'h0000, 6, 0, 1'b1, 8'h08, 8'h00, 16'h4102, 8);
        repeat (3) @(negedge clk);
        check_int("t5_one_fetch", ack_total - acks_before, 1);

        // Ack with no read pending is ignored.
        stray_ack = 1'b1;
        repeat (3) @(negedge clk);
        stray_ack = 1'b0;
        @(negedge clk);
        check1("stray_busy", busy, 1'b0);
        $display("stray ack done");

        // Reset while reading the displacement byte.
        first_delay = 1;
        next_delay = 3;
        exp_addrs.push_back(16'h4103);
        exp_addrs.push_back(16'h4104);
        fetch_go = 1'b1;
        @(negedge clk);
        fetch_go = 1'b0;
        exp_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check1("pre_rst_mem_rd", bus.mem_rd, 1'b1);
        check16("pre_rst_addr", bus.mem_addr, 16'h4104);
        rst = 1'b1;
        #2;
        check1("async_rst_mem_rd", bus.mem_rd, 1'b0);
        check1("async_rst_op_valid", bus.op_valid, 1'b0);
        check16("async_rst_pc", pc, RESET_PC);
        check1("async_rst_busy", busy, 1'b0);
        exp_busy = 1'b0;
        model_pc = RESET_PC;
        exp_addrs.delete();
        next_delay = 0;
        @(negedge clk);
        rst = 1'b0;
        $display("reset during DISP_RD");
        @(negedge clk);
        do_fetch(1'b0, 16'h0000, 1, 0, 1'b0, 8'h01, 8'h00, 16'h0001, 3);
        check_int("t7_reads", rd_log.size(), 1);
        if (rd_log.size() > 0) check16("t7_addr", rd_log[0], 16'h0001);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
